// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It accepts a divide from EX and holds the front of the pipe via `stall`.
// It then returns the quotient or remainder together with the instruction tags,
// marked by a one-cycle `valid` pulse.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for is_div_op_E; operands decoded and latched on accept
//   BUSY  | one restoring-division step per cycle, WIDTH cycles total
//   DONE  | result/tags presented with valid=1; EX advances this cycle
module div_iter_unit #(
    parameter int         WIDTH   = 32,
    parameter logic [4:0] OP_DIV  = 5'd10,
    parameter logic [4:0] OP_DIVU = 5'd11,
    parameter logic [4:0] OP_REM  = 5'd12,
    parameter logic [4:0] OP_REMU = 5'd13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_div_op_E,
    input  logic [4:0]       ALUCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       rd,
    input  logic [31:0]      pc,
    input  logic [31:0]      inst,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic [31:0]      pc_out,
    output logic [31:0]      inst_out,
    output logic             valid,
    output logic             stall
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [4:0]       op;
    logic             neg_q;
    logic             neg_r;
    logic [4:0]       rd_q;
    logic [31:0]      pc_q;
    logic [31:0]      inst_q;

    logic             in_signed;
    logic             in_rem;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic [WIDTH-1:0] special_res;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             op_rem;
    logic [WIDTH-1:0] final_res;

    // Decode the incoming op: signedness, magnitudes and the early-out cases.
    // Unrecognised ALUCtrl codes fall through as DIVU (unsigned quotient).
    always_comb begin
        in_signed   = (ALUCtrl == OP_DIV) || (ALUCtrl == OP_REM);
        in_rem      = (ALUCtrl == OP_REM) || (ALUCtrl == OP_REMU);
        a_mag       = (in_signed && A[WIDTH-1]) ? -A : A;
        b_mag       = (in_signed && B[WIDTH-1]) ? -B : B;
        div_zero    = (B == '0);
        overflow    = in_signed && (A == MIN_NEG) && (B == '1);
        special     = div_zero || overflow;
        if (div_zero) begin
            special_res = in_rem ? A : '1;
        end else begin
            special_res = in_rem ? '0 : MIN_NEG;
        end
    end

    // One restoring step plus the sign fix-up applied on the final step.
    // The partial remainder is always below the divisor, so a borrow-free
    // difference never reaches bit WIDTH; testing that bit too is equivalent
    // and keeps the whole trial result in play.
    always_comb begin
        shifted   = {rem, quo[WIDTH-1]};
        trial     = {1'b0, shifted} - {2'b00, dvsr};
        trial_ok  = ~(trial[WIDTH+1] | trial[WIDTH]);
        rem_next  = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], trial_ok};
        quo_fix   = neg_q ? -quo_next : quo_next;
        rem_fix   = neg_r ? -rem_next : rem_next;
        op_rem    = (op == OP_REM) || (op == OP_REMU);
        final_res = op_rem ? rem_fix : quo_fix;
    end

    // Hold EX while a divide is being accepted or iterated; reset drops it at once.
    assign stall = !rst && (((state == S_IDLE) && is_div_op_E) || (state == S_BUSY));
    assign valid = (state == S_DONE);

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            op       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rd_q     <= '0;
            pc_q     <= '0;
            inst_q   <= '0;
            result   <= '0;
            rd_out   <= '0;
            pc_out   <= '0;
            inst_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div_op_E) begin
                        op     <= ALUCtrl;
                        rd_q   <= rd;
                        pc_q   <= pc;
                        inst_q <= inst;
                        if (special) begin
                            result   <= special_res;
                            rd_out   <= rd;
                            pc_out   <= pc;
                            inst_out <= inst;
                            state    <= S_DONE;
                        end else begin
                            rem   <= '0;
                            quo   <= a_mag;
                            dvsr  <= b_mag;
                            neg_q <= in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r <= in_signed && A[WIDTH-1];
                            cnt   <= '0;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        result   <= final_res;
                        rd_out   <= rd_q;
                        pc_out   <= pc_q;
                        inst_out <= inst_q;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: scenario tasks with a plain-arithmetic reference model for div_iter_unit.
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_div_op_E;
    logic [4:0]  ALUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid;
    logic        stall;

    int n_checks = 0;
    int n_pass   = 0;

    logic [33:0] obs_stall;
    logic [33:0] obs_valid;
    logic [31:0] obs_result;
    logic [4:0]  obs_rd;
    logic [31:0] obs_pc;
    logic [31:0] obs_inst;

    div_iter_unit dut (
        .clk(clk), .rst(rst), .is_div_op_E(is_div_op_E), .ALUCtrl(ALUCtrl),
        .A(A), .B(B), .rd(rd), .pc(pc), .inst(inst),
        .result(result), .rd_out(rd_out), .pc_out(pc_out), .inst_out(inst_out),
        .valid(valid), .stall(stall)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics with 64-bit arithmetic; lat = cycles from issue to valid.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output int lat);
        bit     sgn;
        bit     isrem;
        longint sa, sb, q, r;
        sgn   = (op == 5'd10) || (op == 5'd12);
        isrem = (op == 5'd12) || (op == 5'd13);
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (b == 32'd0) begin
            res = isrem ? a : 32'hFFFF_FFFF;
            lat = 1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = isrem ? r[31:0] : q[31:0];
            lat = (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : 33;
        end
    endfunction

    // Issue one divide and record n cycles of stall/valid plus the first valid payload.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t_rd, input logic [31:0] t_pc, input logic [31:0] t_inst,
                          input int n, input bit scramble);
        bit got;
        got = 1'b0;
        obs_stall = '0; obs_valid = '0;
        obs_result = 'x; obs_rd = 'x; obs_pc = 'x; obs_inst = 'x;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                is_div_op_E = 1'b1; ALUCtrl = op; A = a; B = b;
                rd = t_rd; pc = t_pc; inst = t_inst;
            end else if (scramble) begin
                ALUCtrl = 5'($urandom); A = $urandom; B = $urandom;
                rd = 5'($urandom); pc = $urandom; inst = $urandom;
            end
            #1;
            obs_stall[k] = stall;
            obs_valid[k] = valid;
            if (valid === 1'b1 && !got) begin
                got = 1'b1;
                obs_result = result; obs_rd = rd_out; obs_pc = pc_out; obs_inst = inst_out;
            end
        end
    endtask

    task automatic idle_cycle(output logic s, output logic v, output logic [31:0] r);
        @(negedge clk);
        is_div_op_E = 1'b0;
        #1;
        s = stall; v = valid; r = result;
    endtask

    task automatic test_reset();
        rst = 1'b1; is_div_op_E = 1'b1; ALUCtrl = 5'd10; A = 32'd100; B = 32'd7;
        rd = 5'd3; pc = 32'h100; inst = 32'h2000_0033;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall);
        else n_pass++;
        n_checks++;
        if ({valid, result, rd_out, pc_out, inst_out} !== 102'd0)
            $display("FAIL reset_outputs: valid=%b result=%h rd=%h pc=%h inst=%h want all 0",
                     valid, result, rd_out, pc_out, inst_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; is_div_op_E = 1'b0;
    endtask

    task automatic test_directed();
        logic [4:0]  ops  [5] = '{5'd10, 5'd12, 5'd10, 5'd12, 5'd11};
        logic [31:0] as   [5] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bs   [5] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2};
        logic [31:0] exps [5] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
        logic s, v;
        logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 1), 32'h400 + 32'(i * 4), 32'hABC0_0000 + 32'(i), 34, 1'b0);
            n_checks++;
            if (obs_result !== exps[i]) $display("FAIL dir_result[%0d]: got %h want %h", i, obs_result, exps[i]);
            else n_pass++;
            n_checks++;
            if (obs_stall !== 34'h1_FFFF_FFFF || obs_valid !== 34'h2_0000_0000)
                $display("FAIL dir_timing[%0d]: stall=%h valid=%h want 1ffffffff/200000000", i, obs_stall, obs_valid);
            else n_pass++;
            n_checks++;
            if ({obs_rd, obs_pc, obs_inst} !== {5'(i + 1), 32'h400 + 32'(i * 4), 32'hABC0_0000 + 32'(i)})
                $display("FAIL dir_tags[%0d]: rd=%h pc=%h inst=%h", i, obs_rd, obs_pc, obs_inst);
            else n_pass++;
            idle_cycle(s, v, r);
            n_checks++;
            if ({s, v, r} !== {1'b0, 1'b0, exps[i]})
                $display("FAIL dir_after[%0d]: stall=%b valid=%b result=%h want 0/0/%h", i, s, v, r, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_special();
        logic [4:0]  ops  [5] = '{5'd11, 5'd13, 5'd10, 5'd12, 5'd12};
        logic [31:0] as   [5] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
        logic [31:0] bs   [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exps [5] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'hFFFF_FFFB};
        logic s, v;
        logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], 5'd20 + 5'(i), 32'h800 + 32'(i), 32'h5555_0000 + 32'(i), 2, 1'b0);
            n_checks++;
            if (obs_result !== exps[i]) $display("FAIL spc_result[%0d]: got %h want %h", i, obs_result, exps[i]);
            else n_pass++;
            n_checks++;
            if (obs_stall[1:0] !== 2'b01 || obs_valid[1:0] !== 2'b10)
                $display("FAIL spc_timing[%0d]: stall=%b valid=%b want 01/10", i, obs_stall[1:0], obs_valid[1:0]);
            else n_pass++;
            n_checks++;
            if ({obs_rd, obs_pc, obs_inst} !== {5'd20 + 5'(i), 32'h800 + 32'(i), 32'h5555_0000 + 32'(i)})
                $display("FAIL spc_tags[%0d]: rd=%h pc=%h inst=%h", i, obs_rd, obs_pc, obs_inst);
            else n_pass++;
            idle_cycle(s, v, r);
            n_checks++;
            if ({s, v} !== 2'b00) $display("FAIL spc_after[%0d]: stall=%b valid=%b want 0/0", i, s, v);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, e1, e2;
        int l1, l2;
        a1 = $urandom; b1 = $urandom_range(1, 1000);
        a2 = $urandom; b2 = $urandom | 32'h1;
        model(5'd11, a1, b1, e1, l1);
        model(5'd10, a2, b2, e2, l2);
        run_op(5'd11, a1, b1, 5'd7, 32'h1000, 32'h1111, l1 + 1, 1'b0);
        n_checks++;
        if (obs_result !== e1 || obs_valid !== (34'd1 << l1))
            $display("FAIL b2b_first: result=%h valid=%h want %h at %0d", obs_result, obs_valid, e1, l1);
        else n_pass++;
        run_op(5'd10, a2, b2, 5'd8, 32'h1004, 32'h2222, l2 + 1, 1'b0);
        n_checks++;
        if (obs_result !== e2 || obs_rd !== 5'd8 || obs_stall !== ((34'd1 << l2) - 34'd1))
            $display("FAIL b2b_second: result=%h rd=%h stall=%h want %h/08", obs_result, obs_rd, obs_stall, e2);
        else n_pass++;
        @(negedge clk);
        is_div_op_E = 1'b0;
    endtask

    task automatic test_rst_abort();
        int vcount;
        logic s, v;
        logic [31:0] r;
        @(negedge clk);
        is_div_op_E = 1'b1; ALUCtrl = 5'd10; A = 32'd100; B = 32'd7;
        rd = 5'd9; pc = 32'h900; inst = 32'h9999;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL abort_stall: got %b want 0", stall);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; is_div_op_E = 1'b0;
        #1;
        n_checks++;
        if ({valid, stall, result, rd_out, pc_out, inst_out} !== 103'd0)
            $display("FAIL abort_outputs: valid=%b stall=%b result=%h rd=%h pc=%h inst=%h want all 0",
                     valid, stall, result, rd_out, pc_out, inst_out);
        else n_pass++;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (valid === 1'b1) vcount++;
        end
        n_checks++;
        if (vcount != 0) $display("FAIL abort_no_valid: %0d valid pulses want 0", vcount);
        else n_pass++;
        run_op(5'd11, 32'd9, 32'd3, 5'd1, 32'h40, 32'h41, 34, 1'b0);
        n_checks++;
        if (obs_result !== 32'd3 || obs_valid !== 34'h2_0000_0000)
            $display("FAIL abort_fresh: result=%h valid=%h want 3 at cycle 33", obs_result, obs_valid);
        else n_pass++;
        idle_cycle(s, v, r);
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] a, b, e;
        logic [4:0]  t_rd;
        logic [31:0] t_pc, t_inst;
        int lat, sel;
        logic s, v;
        logic [31:0] r;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            op  = (sel == 9) ? 5'($urandom_range(14, 31)) : 5'd10 + 5'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = -32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            t_rd = 5'($urandom); t_pc = $urandom; t_inst = $urandom;
            model(op, a, b, e, lat);
            run_op(op, a, b, t_rd, t_pc, t_inst, lat + 1, 1'b1);
            n_checks++;
            if (obs_result !== e || obs_stall !== ((34'd1 << lat) - 34'd1) || obs_valid !== (34'd1 << lat)
                || {obs_rd, obs_pc, obs_inst} !== {t_rd, t_pc, t_inst})
                $display("FAIL rnd[%0d]: op=%0d a=%h b=%h result=%h want %h stall=%h valid=%h lat=%0d",
                         i, op, a, b, obs_result, e, obs_stall, obs_valid, lat);
            else n_pass++;
            if ($urandom_range(0, 1) == 0) idle_cycle(s, v, r);
        end
        idle_cycle(s, v, r);
    endtask

    initial begin
        rst = 1'b1; is_div_op_E = 1'b0; ALUCtrl = '0; A = '0; B = '0;
        rd = '0; pc = '0; inst = '0;
        test_reset();
        test_directed();
        test_special();
        test_back_to_back();
        test_rst_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
